// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between a load/store unit (master) and data_mem_ctrl (slave).
// Requests use a valid/ready handshake. Responses are a one-cycle pulse with no backpressure.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32 data-memory controller with a little-endian byte-lane RAM.
// It handles byte, halfword and word stores with per-lane write enables.
// Loads are returned sign- or zero-extended.
// Optional feature macro: MISALIGN_SPLIT_EN. When it is defined, a misaligned
// half/word access is split into two word accesses through a SPLIT state.
// Without it, a misaligned access faults. SIZE=11 faults in both builds.
module data_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 4096   // power of 2, <= 2**(ADDR_W-2)
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Request decode
    logic [ADDR_W-1:0] addr;
    logic              unused_addr;
    logic [1:0]        off;
    logic [IDX_W-1:0]  idx;
    logic              accept, illegal, misaligned, fault_req, store_now;
    logic [3:0]        size_mask;
    logic [7:0]        lane_mask8;   // lane enables across word i (bits 3:0) and word i+1 (bits 7:4)
    logic [63:0]       wdata64;      // store data shifted onto the byte lanes of words i and i+1

    // Control registers
    logic              req_ready_reg, rsp_valid_reg, rsp_fault_reg, rsp_load_reg;
    logic              req_ready_next, rsp_valid_next, rsp_fault_next, rsp_load_next;
    logic [1:0]        off_reg, size_reg;
    logic              signed_reg;

    // RAM port
    logic [IDX_W-1:0]  ram_idx;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       rd_word;

    // Response formatting
    logic [63:0]       pair;
    logic [31:0]       raw, ext;

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t            state_reg, state_next;
    logic              rsp_split_reg, rsp_split_next;
    logic              pend_load_reg;
    logic [IDX_W-1:0]  hi_idx_reg;
    logic [3:0]        hi_we_reg;
    logic [31:0]       hi_data_reg;
    logic [31:0]       lo_word_reg;
`else
    logic              unused_hi;
    assign unused_hi = ^{wdata64[63:32], lane_mask8[7:4]};
`endif

    assign addr        = bus.req_addr;
    assign unused_addr = ^addr;   // upper address bits alias onto the RAM
    assign off         = addr[1:0];
    assign idx         = addr[IDX_W+1:2];
    // Requests are only taken outside reset, so a valid held during reset never writes.
    assign accept      = bus.req_valid & req_ready_reg & rst_n;
    assign illegal     = (bus.req_size == 2'b11);
    assign misaligned  = ((bus.req_size == 2'b01) && off[0]) ||
                         ((bus.req_size == 2'b10) && (off != 2'b00));
`ifdef MISALIGN_SPLIT_EN
    assign fault_req   = illegal;
`else
    assign fault_req   = illegal | misaligned;
`endif
    assign store_now   = accept & bus.req_we & ~fault_req;
    assign lane_mask8  = {4'b0000, size_mask} << off;
    assign wdata64     = {32'h0, bus.req_wdata} << {off, 3'b000};

    // Lane mask for the access size, before shifting to the byte offset
    always_comb begin
        size_mask = 4'b0000;
        case (bus.req_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    end

    // RAM port mux: the request's word normally, the word after it during SPLIT
    always_comb begin
        ram_idx   = idx;
        ram_we    = store_now ? lane_mask8[3:0] : 4'b0000;
        ram_wdata = wdata64[31:0];
`ifdef MISALIGN_SPLIT_EN
        if (state_reg == SPLIT) begin
            ram_idx   = hi_idx_reg;
            ram_we    = hi_we_reg;
            ram_wdata = hi_data_reg;
        end
`endif
    end

    // Byte-lane RAM with a registered read (read-first), contents not reset
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_lane;
        always_ff @(posedge clk) begin
            if (ram_we[gi]) lane_mem[ram_idx] <= ram_wdata[gi*8 +: 8];
            rd_lane <= lane_mem[ram_idx];
        end
        assign rd_word[gi*8 +: 8] = rd_lane;
    end

    // Next-state and response logic
    always_comb begin
        req_ready_next = 1'b1;
        rsp_valid_next = 1'b0;
        rsp_fault_next = 1'b0;
        rsp_load_next  = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        state_next     = state_reg;
        rsp_split_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && misaligned && !illegal) begin
                    state_next     = SPLIT;
                    req_ready_next = 1'b0;
                end else if (accept) begin
                    rsp_valid_next = 1'b1;
                    rsp_fault_next = fault_req;
                    rsp_load_next  = ~bus.req_we & ~fault_req;
                end
            end
            SPLIT: begin
                state_next     = IDLE;
                rsp_valid_next = 1'b1;
                rsp_load_next  = pend_load_reg;
                rsp_split_next = 1'b1;
            end
        endcase
`else
        if (accept) begin
            rsp_valid_next = 1'b1;
            rsp_fault_next = fault_req;
            rsp_load_next  = ~bus.req_we & ~fault_req;
        end
`endif
    end

`ifdef MISALIGN_SPLIT_EN
    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end
`endif

    // Control registers and fields captured at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_fault_reg <= 1'b0;
            rsp_load_reg  <= 1'b0;
            off_reg       <= 2'b00;
            size_reg      <= 2'b00;
            signed_reg    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            rsp_split_reg <= 1'b0;
            pend_load_reg <= 1'b0;
            hi_idx_reg    <= '0;
            hi_we_reg     <= 4'b0000;
            hi_data_reg   <= 32'h0;
            lo_word_reg   <= 32'h0;
`endif
        end else begin
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_fault_reg <= rsp_fault_next;
            rsp_load_reg  <= rsp_load_next;
            if (accept) begin
                off_reg    <= off;
                size_reg   <= bus.req_size;
                signed_reg <= bus.req_signed;
            end
`ifdef MISALIGN_SPLIT_EN
            rsp_split_reg <= rsp_split_next;
            if (accept) begin
                pend_load_reg <= ~bus.req_we;
                hi_idx_reg    <= idx + IDX_W'(1);   // wraps past the last word
                hi_we_reg     <= bus.req_we ? lane_mask8[7:4] : 4'b0000;
                hi_data_reg   <= wdata64[63:32];
            end
            // Keep word i while word i+1 is read during SPLIT
            if (state_reg == SPLIT) lo_word_reg <= rd_word;
`endif
        end
    end

    // Align and extend load data using only registered state, so the
    // response has no combinational path from the request inputs.
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        pair = rsp_split_reg ? {rd_word, lo_word_reg} : {rd_word, rd_word};
`else
        pair = {rd_word, rd_word};
`endif
        raw = 32'(pair >> {off_reg, 3'b000});
        case (size_reg)
            2'b00:   ext = signed_reg ? {{24{raw[7]}},  raw[7:0]}  : {24'h0, raw[7:0]};
            2'b01:   ext = signed_reg ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_fault = rsp_fault_reg;
    assign bus.rsp_rdata = rsp_load_reg ? ext : 32'h0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed, table-driven testbench for data_mem_ctrl. Expectations follow the
// build: MISALIGN_SPLIT_EN selects split or fault behaviour for misaligned accesses.
module tb_data_mem_ctrl;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_BUILD = 1'b1;
`else
    localparam bit SPLIT_BUILD = 1'b0;
`endif
    localparam int SPLIT_LAT = SPLIT_BUILD ? 2 : 1;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    vec_t vecs[$];

    data_mem_ctrl_if #(.ADDR_W(16)) bus ();

    data_mem_ctrl #(.ADDR_W(16), .DEPTH_WORDS(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic sgn, input logic [31:0] er,
                                input logic ef, input int el);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Issue one request and wait (bounded) for its response pulse
    task automatic xact(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sgn,
                        output logic [31:0] rdata, output logic fault, output int lat,
                        output logic ready1);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_size = size; bus.req_signed = sgn;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
        lat = 0; rdata = 32'hxxxxxxxx; fault = 1'bx; ready1 = 1'bx;
        for (int c = 1; c <= 4 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) ready1 = bus.req_ready;
            if (bus.rsp_valid) begin
                lat = c; rdata = bus.rsp_rdata; fault = bus.rsp_fault;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] rdata;
        logic        fault, ready1;
        int          lat;
        xact(v.we, v.addr, v.wdata, v.size, v.sgn, rdata, fault, lat, ready1);
        $display("%s: we=%0b addr=%h size=%0d sgn=%0b -> lat=%0d rdata=%h fault=%b",
                 tag, v.we, v.addr, v.size, v.sgn, lat, rdata, fault);
        check($sformatf("%s latency", tag), 32'(lat), 32'(v.exp_lat));
        check($sformatf("%s ready", tag), {31'b0, ready1}, {31'b0, v.exp_lat == 1});
        check($sformatf("%s rdata", tag), rdata, v.exp_rdata);
        check($sformatf("%s fault", tag), {31'b0, fault}, {31'b0, v.exp_fault});
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_size = 2'b00; bus.req_signed = 1'b0;

        vecs.push_back(mk(1, 16'h0000, 32'h000000AB, SZ_B, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 16'h0000, 32'h0,        SZ_B, 0, 32'h000000AB, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 32'h0,        SZ_B, 1, 32'hFFFFFFAB, 0, 1));
        vecs.push_back(mk(1, 16'h0010, 32'h0000CDEF, SZ_H, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 16'h0010, 32'h0,        SZ_H, 0, 32'h0000CDEF, 0, 1));
        vecs.push_back(mk(0, 16'h0010, 32'h0,        SZ_H, 1, 32'hFFFFCDEF, 0, 1));
        vecs.push_back(mk(1, 16'h0020, 32'h12345678, SZ_W, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 16'h0023, 32'h0,        SZ_B, 0, 32'h00000012, 0, 1));
        vecs.push_back(mk(0, 16'h0022, 32'h0,        SZ_H, 1, 32'h00001234, 0, 1));
        vecs.push_back(mk(0, 16'h0020, 32'h0,        SZ_W, 1, 32'h12345678, 0, 1));
        vecs.push_back(mk(0, 16'h0021, 32'h0,        SZ_B, 1, 32'h00000056, 0, 1));
        vecs.push_back(mk(1, 16'h0021, 32'hFFFFFFCC, SZ_B, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 16'h0020, 32'h0,        SZ_W, 0, 32'h1234CC78, 0, 1));
        vecs.push_back(mk(0, 16'h4020, 32'h0,        SZ_W, 0, 32'h1234CC78, 0, 1));
        vecs.push_back(mk(0, 16'h0021, 32'h0,        SZ_B, 1, 32'hFFFFFFCC, 0, 1));
        vecs.push_back(mk(1, 16'h0020, 32'hFFFFFFFF, SZ_X, 0, 32'h0,        1, 1));
        vecs.push_back(mk(0, 16'h0020, 32'h0,        SZ_X, 1, 32'h0,        1, 1));
        vecs.push_back(mk(0, 16'h0020, 32'h0,        SZ_W, 0, 32'h1234CC78, 0, 1));
        vecs.push_back(mk(1, 16'h0000, 32'h0,        SZ_W, 0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 16'h0004, 32'h0,        SZ_W, 0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 16'h0001, 32'h11223344, SZ_W, 0, 32'h0, !SPLIT_BUILD, SPLIT_LAT));
        vecs.push_back(mk(0, 16'h0000, 32'h0,        SZ_W, 0, SPLIT_BUILD ? 32'h22334400 : 32'h0, 0, 1));
        vecs.push_back(mk(0, 16'h0004, 32'h0,        SZ_W, 0, SPLIT_BUILD ? 32'h00000011 : 32'h0, 0, 1));
        vecs.push_back(mk(0, 16'h0001, 32'h0,        SZ_W, 0, SPLIT_BUILD ? 32'h11223344 : 32'h0, !SPLIT_BUILD, SPLIT_LAT));
        vecs.push_back(mk(0, 16'h0003, 32'h0,        SZ_H, 1, SPLIT_BUILD ? 32'h00001122 : 32'h0, !SPLIT_BUILD, SPLIT_LAT));
        vecs.push_back(mk(0, 16'h0001, 32'h0,        SZ_H, 1, SPLIT_BUILD ? 32'h00003344 : 32'h0, !SPLIT_BUILD, SPLIT_LAT));
        vecs.push_back(mk(1, 16'h0005, 32'h0000BEEF, SZ_H, 0, 32'h0, !SPLIT_BUILD, SPLIT_LAT));
        vecs.push_back(mk(0, 16'h0004, 32'h0,        SZ_W, 0, SPLIT_BUILD ? 32'h00BEEF11 : 32'h0, 0, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset rsp_fault", {31'b0, bus.rsp_fault}, 32'h0);
        $display("reset: ready=%b valid=%b rdata=%h fault=%b",
                 bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back store then load to the same word
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h0030;
        bus.req_wdata = 32'hA5A55A5A; bus.req_size = SZ_W; bus.req_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.req_we = 1'b0; bus.req_wdata = 32'h0;
        @(negedge clk);
        $display("b2b store: valid=%b rdata=%h fault=%b", bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault);
        check("b2b store valid", {31'b0, bus.rsp_valid}, 32'h1);
        check("b2b store rdata", bus.rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        $display("b2b load: valid=%b rdata=%h fault=%b", bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault);
        check("b2b load valid", {31'b0, bus.rsp_valid}, 32'h1);
        check("b2b load rdata", bus.rsp_rdata, 32'hA5A55A5A);
        @(negedge clk);
        check("b2b idle valid", {31'b0, bus.rsp_valid}, 32'h0);

        // Split across the last word, wrapping to word 0
        run_vec(mk(1, 16'h3FFC, 32'h0,        SZ_W, 0, 32'h0, 0, 1), "wrap init top");
        run_vec(mk(1, 16'h0000, 32'h55555555, SZ_W, 0, 32'h0, 0, 1), "wrap init w0");
        run_vec(mk(1, 16'h3FFE, 32'hAABBCCDD, SZ_W, 0, 32'h0, !SPLIT_BUILD, SPLIT_LAT), "wrap store");
        run_vec(mk(0, 16'h3FFC, 32'h0, SZ_W, 0, SPLIT_BUILD ? 32'hCCDD0000 : 32'h0, 0, 1), "wrap top");
        run_vec(mk(0, 16'h0000, 32'h0, SZ_W, 0, SPLIT_BUILD ? 32'h5555AABB : 32'h55555555, 0, 1), "wrap w0");

`ifdef MISALIGN_SPLIT_EN
        // Reset asserted during SPLIT: first half committed, no response, word 0 untouched
        run_vec(mk(1, 16'h3FFC, 32'h0,        SZ_W, 0, 32'h0, 0, 1), "rst init top");
        run_vec(mk(1, 16'h0000, 32'h55555555, SZ_W, 0, 32'h0, 0, 1), "rst init w0");
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h3FFE;
        bus.req_wdata = 32'h11223344; bus.req_size = SZ_W; bus.req_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
        @(negedge clk);
        check("rst split ready", {31'b0, bus.req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst valid during reset", {31'b0, bus.rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("rst valid after edge", {31'b0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("rst mid-split: valid=%b ready=%b", bus.rsp_valid, bus.req_ready);
        check("rst valid after release", {31'b0, bus.rsp_valid}, 32'h0);
        check("rst ready after release", {31'b0, bus.req_ready}, 32'h1);
        run_vec(mk(0, 16'h3FFC, 32'h0, SZ_W, 0, 32'h33440000, 0, 1), "rst top");
        run_vec(mk(0, 16'h0000, 32'h0, SZ_W, 0, 32'h55555555, 0, 1), "rst w0");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
